display_scan: RTL and testbench

- Time-multiplexes one shared 2-out-of-5 seven-segment decoder across DIGITS common-cathode digits.
- Holds an active and a shadow register of 2-of-5 codes, one code per digit.
- Drives the decoder's code inputs (a..e) and valid input (v), and the per-digit enables.
- Inserts blanking between digit slots to prevent ghosting.
- Accepts new frame data through a load/ready handshake; the swap is frame-aligned.

---
 rtl/display_scan.sv | 180 ++++++++++++++++++
 tb/tb_display_scan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: time-multiplexes one shared 2-of-5 seven-segment decoder
// across DIGITS common-cathode digits, with blanking between digit slots
// and a frame-aligned active/shadow register swap driven by load/ready.
// Optional blink support is compiled in with `define DISPLAY_SCAN_BLINK_EN.
module display_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
`ifdef DISPLAY_SCAN_BLINK_EN
  , parameter int BLINK_LOG2 = 5
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   code_in,
`ifdef DISPLAY_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  output logic                  ready,
  output logic [4:0]            dig_code,
  output logic                  dig_v,
  output logic [DIGITS-1:0]     an,
  output logic [DIGITS-1:0]     err
);

  localparam int CMAX = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(DIGITS);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  // True when the 5-bit code has exactly two bits set.
  function automatic logic is_2of5(input logic [4:0] c);
    logic [2:0] s;
    s = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]} + {2'b00, c[4]};
    return (s == 3'd2);
  endfunction

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [IW-1:0]            r_idx;
  logic [DIGITS-1:0]        r_an;
  logic [4:0]               r_dig_code;
  logic                     r_dig_v;
  logic [DIGITS-1:0][4:0]   r_active;
  logic [DIGITS-1:0][4:0]   r_shadow;
  logic                     r_pending;
  logic                     r_ready;
  logic [DIGITS-1:0]        r_err;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [BLINK_LOG2:0]      r_fcnt;
`endif

  logic [DIGITS-1:0][4:0]   w_code_in;
  logic [CW-1:0]            w_last_cnt;
  logic                     w_slot_end;
  logic                     w_boundary;
  logic                     w_accept;
  logic [IW-1:0]            w_next_idx;
  logic [4:0]               w_next_code;
  logic [DIGITS-1:0]        w_show_an;
  logic [DIGITS-1:0]        w_err_new;

  assign w_code_in = code_in;

  // Slot timing, frame boundary detection and next-slot decoder data.
  always_comb begin
    w_last_cnt = (r_state == ST_SHOW) ? SHOW_LAST : BLANK_LAST;
    w_slot_end = (r_cnt == w_last_cnt);
    w_boundary = (r_state == ST_SHOW) && w_slot_end && (r_idx == IDX_LAST);
    w_accept   = load && r_ready;
    if (r_idx == IDX_LAST) begin
      w_next_idx = '0;
    end else begin
      w_next_idx = r_idx + IW'(1);
    end
    // On a swapping boundary the new frame's digit 0 comes straight from shadow.
    if (w_boundary && r_pending) begin
      w_next_code = r_shadow[0];
    end else begin
      w_next_code = r_active[w_next_idx];
    end
    w_show_an = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
`ifdef DISPLAY_SCAN_BLINK_EN
    if (r_fcnt[BLINK_LOG2]) begin
      w_show_an = w_show_an & ~blink;
    end else begin
      w_show_an = w_show_an;
    end
`endif
    for (int i = 0; i < DIGITS; i++) begin
      w_err_new[i] = ~is_2of5(w_code_in[i]);
    end
  end

  // Scan state machine: BLANK/SHOW slots, digit index and registered decoder drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_an       <= '0;
      r_dig_code <= 5'b00000;
      r_dig_v    <= 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
      r_fcnt     <= '0;
`endif
    end else begin
      case (r_state)
        ST_BLANK: begin
          if (w_slot_end) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_an    <= w_show_an;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        ST_SHOW: begin
          if (w_slot_end) begin
            r_state    <= ST_BLANK;
            r_cnt      <= '0;
            r_an       <= '0;
            r_idx      <= w_next_idx;
            r_dig_code <= w_next_code;
            r_dig_v    <= is_2of5(w_next_code);
`ifdef DISPLAY_SCAN_BLINK_EN
            if (w_boundary) begin
              r_fcnt <= r_fcnt + (BLINK_LOG2+1)'(1);
            end
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ST_BLANK;
          r_cnt   <= '0;
          r_an    <= '0;
        end
      endcase
    end
  end

  // Load handshake into shadow and frame-aligned shadow-to-active swap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_err     <= '0;
    end else begin
      if (w_boundary && r_pending) begin
        r_active <= r_shadow;
      end
      // A load taken on the boundary cycle stays pending until the next boundary.
      if (w_accept) begin
        r_shadow  <= w_code_in;
        r_err     <= w_err_new;
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end
    end
  end

  assign an       = r_an;
  assign dig_code = r_dig_code;
  assign dig_v    = r_dig_v;
  assign ready    = r_ready;
  assign err      = r_err;

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan (DIGITS=4, PRESCALE=8, BLANK=2).
module tb_display_scan;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;

  logic        clk;
  logic        rst;
  logic        load;
  logic [19:0] code_in;
  logic        ready;
  logic [4:0]  dig_code;
  logic        dig_v;
  logic [3:0]  an;
  logic [3:0]  err;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [3:0]  blink;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [4:0] code;
    logic       v;
  } slot_t;
  slot_t sb_q[$];

  localparam logic [19:0] F2 = {5'b11000, 5'b00011, 5'b10100, 5'b01010};
  localparam logic [19:0] F3 = {5'b10001, 5'b11100, 5'b00110, 5'b01100};
  localparam logic [19:0] FA = {5'b00101, 5'b10010, 5'b01001, 5'b00011};
  localparam logic [19:0] FB = {5'b11111, 5'b00000, 5'b11000, 5'b10100};

  display_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .code_in  (code_in),
`ifdef DISPLAY_SCAN_BLINK_EN
    .blink    (blink),
`endif
    .ready    (ready),
    .dig_code (dig_code),
    .dig_v    (dig_v),
    .an       (an),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: at the start of each SHOW slot, compare against the next expected slot.
  logic [3:0] mon_prev = 4'b0000;
  always @(negedge clk) begin : mon
    slot_t e;
    if (an != 4'b0000 && mon_prev == 4'b0000 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if ({an, dig_code, dig_v} !== e) begin
        bad++;
        $display("FAIL slot: got an=%b code=%b v=%b, expected an=%b code=%b v=%b",
                 an, dig_code, dig_v, e.an, e.code, e.v);
      end
    end
    mon_prev <= an;
  end

  task automatic push_frame(input logic [19:0] codes, input logic [3:0] vs);
    slot_t e;
    for (int i = 0; i < 4; i++) begin
      e.an   = 4'b0001 << i;
      e.code = codes[5*i +: 5];
      e.v    = vs[i];
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Returns at the first negedge after a frame boundary (digit 3 slot just ended).
  task automatic wait_frame_start();
    logic [3:0] p;
    int n;
    logic seen;
    p = an;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (p == 4'b1000 && an == 4'b0000) seen = 1'b1;
      p = an;
    end
    chk("frame_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n;
    n = 0;
    while (an != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("an_wait", an, target);
  endtask

  task automatic load_frame(input logic [19:0] codes);
    load = 1'b1;
    code_in = codes;
    @(negedge clk);
    load = 1'b0;
    #1;
  endtask

  initial begin
    int t_rise[4];
    int nr;
    int n;
    logic p0;
    logic [3:0] exp_an;

    rst = 1'b1;
    load = 1'b0;
    code_in = 20'd0;
`ifdef DISPLAY_SCAN_BLINK_EN
    blink = 4'b0000;
`endif
    #1;
    chk("rst_an", an, 4'b0000);
    chk("rst_code", dig_code, 5'b00000);
    chk("rst_v", dig_v, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_err", err, 4'b0000);

    // Test 1: scan timing after release, no load.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k < 2)       exp_an = 4'b0000;
      else if (k < 10) exp_an = 4'b0001;
      else if (k < 12) exp_an = 4'b0000;
      else             exp_an = 4'b0010;
      chk("t1_an", an, exp_an);
      chk("t1_code", dig_code, 5'b00000);
      chk("t1_v", dig_v, 1'b0);
      chk("t1_ready", ready, 1'b1);
      chk("t1_err", err, 4'b0000);
    end

    // Test 2: valid frame, swap at the next boundary.
    load_frame(F2);
    chk("t2_ready_lo", ready, 1'b0);
    chk("t2_err", err, 4'b0000);
    wait_frame_start();
    #1;
    chk("t2_ready_hi", ready, 1'b1);
    push_frame(F2, 4'b1111);
    drain();

    // Test 3: digit 2 not 2-of-5.
    chk("t3_ready", ready, 1'b1);
    load_frame(F3);
    chk("t3_err", err, 4'b0100);
    wait_frame_start();
    push_frame(F3, 4'b1011);
    drain();

    // Test 4: second load while busy is ignored; later it is taken.
    chk("t4_ready_a", ready, 1'b1);
    load_frame(FA);
    chk("t4_ready_lo", ready, 1'b0);
    load_frame(FB);
    chk("t4_ready_lo2", ready, 1'b0);
    chk("t4_err_a", err, 4'b0000);
    wait_frame_start();
    push_frame(FA, 4'b1111);
    drain();
    chk("t4_ready_b", ready, 1'b1);
    chk("t4_err_keep", err, 4'b0000);
    load_frame(FB);
    chk("t4_err_b", err, 4'b1100);
    wait_frame_start();
    push_frame(FB, 4'b0011);
    drain();

    // Test 5: async reset mid-frame discards pending data.
    load_frame(FA);
    wait_frame_start();
    #1;
    load_frame(FB);
    wait_an(4'b0100);
    chk("t5_v_pre", dig_v, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_an_async", an, 4'b0000);
    chk("t5_v_async", dig_v, 1'b0);
    chk("t5_ready", ready, 1'b1);
    chk("t5_err", err, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("t5_an", an, (k < 2) ? 4'b0000 : 4'b0001);
    end
    chk("t5_code", dig_code, 5'b00000);
    chk("t5_v", dig_v, 1'b0);
    wait_frame_start();
    push_frame(20'd0, 4'b0000);
    drain();

    // Test 6: digit 0 rising-edge spacing over three frames.
    nr = 0;
    n = 0;
    p0 = an[0];
    while (nr < 4 && n < 300) begin
      @(negedge clk);
      n++;
      if (an[0] && !p0) begin
        t_rise[nr] = cyc;
        nr++;
      end
      p0 = an[0];
    end
    chk("t6_rises", nr, 4);
    if (nr == 4) begin
      for (int i = 1; i < 4; i++) begin
        chk("t6_period", t_rise[i] - t_rise[i-1], 40);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
